// File: rtl/sys_array_pkg.sv
// rtl/sys_array_pkg.sv - shared types and helpers for the systolic-array lock arbiters
//
// Purpose: arbiter state encoding, address/payload width convention and an
//          index-width helper shared by the comp and load lock arbiters.
// Ports:   none (package).
package sys_array_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int ADDR_W       = 32;
   // One payload carries the A, D and C addresses.
   localparam int SA_PAYLOAD_W = 3 * ADDR_W;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sys_array_lock_arbiter_rr_picker.sv
// rtl/sys_array_lock_arbiter_rr_picker.sv - combinational round-robin winner picker
//
// Purpose: selects the first asserted request at or above rr_ptr_i, wrapping
//          modulo NUM_REQ (rotate, priority-encode, un-rotate).
// Ports:   req_i     - per-thread request vector
//          rr_ptr_i  - highest-priority index for this pick
//          winner_o  - index of the selected requester (valid when any_req_o)
//          any_req_o - at least one request is asserted
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [IDX_W-1:0]   winner_o,
   output logic               any_req_o
);

   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   off;
   logic [IDX_W:0]     sum;

   // Rotating the doubled vector right puts req[rr_ptr] at bit 0.
   assign rot       = NUM_REQ'({req_i, req_i} >> rr_ptr_i);
   assign any_req_o = |req_i;

   always_comb begin
      off = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rot[j]) off = IDX_W'(j);
      end
      // rr_ptr < NUM_REQ, so one conditional subtract completes the modulo.
      sum = {1'b0, off} + {1'b0, rr_ptr_i};
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      winner_o = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/sys_array_lock_arbiter.sv
// rtl/sys_array_lock_arbiter.sv - round-robin lock arbiter for one systolic-array port
//
// Purpose: grants exclusive ownership of a sys-array resource port to one of
//          NUM_REQ threads, latches the winner's payload, pulses start, and
//          holds the lock until done or a MAX_HOLD-cycle timeout.
// Ports:   clock, reset  - clock; synchronous active-high reset
//          req           - per-thread level lock requests
//          payload_in    - flattened payloads, requester i at [i*PAYLOAD_W +: PAYLOAD_W]
//          done          - one-cycle finished pulse from the resource
//          grant         - registered one-hot owner
//          start         - one-cycle pulse on the first grant cycle
//          payload_out   - payload latched from the winner
//          busy          - lock held
//          timeout_err   - sticky forced-release flag
//          timeout_id    - owner index at the last forced release
module sys_array_lock_arbiter
   import sys_array_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int PAYLOAD_W = SA_PAYLOAD_W,
   parameter int MAX_HOLD  = 4096
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*PAYLOAD_W-1:0]   payload_in,
   input  logic                           done,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           start,
   output logic [PAYLOAD_W-1:0]           payload_out,
   output logic                           busy,
   output logic                           timeout_err,
   output logic [clog2_min1(NUM_REQ)-1:0] timeout_id
);

   localparam int IDX_W  = clog2_min1(NUM_REQ);
   // One spare bit so the counter reaches MAX_HOLD without wrapping.
   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

   arb_state_t           state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 start_q, start_d;
   logic [PAYLOAD_W-1:0] payload_q, payload_d;
   logic                 err_q, err_d;
   logic [IDX_W-1:0]     tid_q, tid_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     rr_q, rr_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;

   logic [IDX_W-1:0]     winner;
   logic                 any_req;
   logic [PAYLOAD_W-1:0] sel_payload;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i     (req),
      .rr_ptr_i  (rr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   always_comb begin
      sel_payload = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) sel_payload = payload_in[i*PAYLOAD_W +: PAYLOAD_W];
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      start_d   = 1'b0;
      payload_d = payload_q;
      err_d     = err_q;
      tid_d     = tid_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      hold_d    = hold_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d   = BUSY;
               grant_d   = NUM_REQ'(1) << winner;
               start_d   = 1'b1;
               payload_d = sel_payload;
               owner_d   = winner;
               hold_d    = '0;
               // Explicit wrap keeps rr_ptr in range for non-power-of-2 NUM_REQ.
               rr_d      = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
         end
         BUSY: begin
            hold_d = hold_q + 1'b1;
            if (done) begin
               // done wins over a coincident timeout: a clean release.
               state_d = IDLE;
               grant_d = '0;
            end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               state_d = IDLE;
               grant_d = '0;
               err_d   = 1'b1;
               tid_d   = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         start_q   <= 1'b0;
         payload_q <= '0;
         err_q     <= 1'b0;
         tid_q     <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         start_q   <= start_d;
         payload_q <= payload_d;
         err_q     <= err_d;
         tid_q     <= tid_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         hold_q    <= hold_d;
      end
   end

   assign grant       = grant_q;
   assign start       = start_q;
   assign payload_out = payload_q;
   assign busy        = (state_q == BUSY);
   assign timeout_err = err_q;
   assign timeout_id  = tid_q;

endmodule

// File: tb/tb_sys_array_lock_arbiter.sv
// tb/tb_sys_array_lock_arbiter.sv - scoreboard bench for sys_array_lock_arbiter
module tb_sys_array_lock_arbiter;

   localparam int NR = 2;
   localparam int PW = 96;
   localparam int MH = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic [NR-1:0]   req;
   logic [NR*PW-1:0] payload_in;
   logic            done;
   logic [NR-1:0]   grant;
   logic            start;
   logic [PW-1:0]   payload_out;
   logic            busy;
   logic            timeout_err;
   logic [0:0]      timeout_id;

   sys_array_lock_arbiter #(.NUM_REQ(NR), .PAYLOAD_W(PW), .MAX_HOLD(MH)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .payload_in  (payload_in),
      .done        (done),
      .grant       (grant),
      .start       (start),
      .payload_out (payload_out),
      .busy        (busy),
      .timeout_err (timeout_err),
      .timeout_id  (timeout_id)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [NR-1:0] grant;
      logic [PW-1:0] payload;
      int            len;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [PW-1:0] P0 = 96'h000000AA_000000BB_000000CC;
   localparam logic [PW-1:0] P1 = 96'h00000011_00000022_00000033;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [NR-1:0] g, input logic [PW-1:0] p, input int n);
      exp_t e;
      e.grant = g; e.payload = p; e.len = n;
      return e;
   endfunction

   // Monitor: pops an expectation on every start and tracks the tenure.
   initial begin : monitor
      exp_t cur;
      bit   in_ten = 0;
      int   cnt = 0;
      forever begin
         @(negedge clock);
         if (in_ten) begin
            if (busy) begin
               cnt++;
               chk("grant_hold", grant, cur.grant);
               chk("payload_hold", payload_out, cur.payload);
            end else begin
               chk("tenure_len", cnt, cur.len);
               in_ten = 0;
            end
         end
         if (start) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               cur = exp_q.pop_front();
               chk("grant", grant, cur.grant);
               chk("payload", payload_out, cur.payload);
               chk("busy_at_start", busy, 1);
               in_ten = 1;
               cnt = 1;
            end
         end
      end
   end

   task automatic wait_start(output int lat);
      bit ok = 0;
      lat = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clock);
         lat++;
         if (start) ok = 1;
      end
      chk("start_seen", ok, 1);
   endtask

   // Called at the negedge of tenure cycle 1; done is high during cycle k.
   task automatic pulse_done(input int k);
      repeat (k - 1) @(negedge clock);
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; done = 1'b0; payload_in = {P1, P0};
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      reset = 1'b1; req = '0; done = 1'b0; payload_in = {P1, P0};
      repeat (2) @(negedge clock);
      chk("rst_grant", grant, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_payload", payload_out, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_tid", timeout_id, 0);
      reset = 1'b0;

      // 1: single requester, done in the 5th busy cycle
      req = 2'b01;
      exp_q.push_back(mk(2'b01, P0, 5));
      wait_start(lat);
      chk("t1_latency", lat, 1);
      req = '0;
      pulse_done(5);
      chk("t1_grant_after", grant, 0);
      chk("t1_busy_after", busy, 0);

      // 2: both requesting, alternating grants with one idle cycle between
      do_reset();
      req = 2'b11;
      exp_q.push_back(mk(2'b01, P0, 3));
      exp_q.push_back(mk(2'b10, P1, 3));
      exp_q.push_back(mk(2'b01, P0, 3));
      for (int t = 0; t < 3; t++) begin
         wait_start(lat);
         chk("t2_latency", lat, 1);
         if (t == 2) req = '0;
         pulse_done(3);
         chk("t2_idle_gap", busy, 0);
      end

      // 5: owner drops req, payload toggles, lock and payload held
      do_reset();
      req = 2'b11;
      exp_q.push_back(mk(2'b01, P0, 4));
      exp_q.push_back(mk(2'b10, P1, 2));
      wait_start(lat);
      req = 2'b10;
      repeat (3) begin
         @(negedge clock);
         payload_in[PW-1:0] = ~payload_in[PW-1:0];
      end
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
      payload_in = {P1, P0};
      wait_start(lat);
      chk("t5_latency", lat, 1);
      req = '0;
      pulse_done(2);

      // 4: done on the last allowed cycle is a normal release
      do_reset();
      req = 2'b01;
      exp_q.push_back(mk(2'b01, P0, 8));
      wait_start(lat);
      req = '0;
      pulse_done(8);
      chk("t4_grant_after", grant, 0);
      chk("t4_terr", timeout_err, 0);

      // 3: no done -> forced release after 8 cycles, sticky error
      do_reset();
      req = 2'b10;
      exp_q.push_back(mk(2'b10, P1, 8));
      wait_start(lat);
      req = '0;
      repeat (8) @(negedge clock);
      chk("t3_grant_after", grant, 0);
      chk("t3_terr", timeout_err, 1);
      chk("t3_tid", timeout_id, 1);
      req = 2'b01;
      exp_q.push_back(mk(2'b01, P0, 3));
      wait_start(lat);
      chk("t3_regrant_latency", lat, 1);
      req = '0;
      pulse_done(3);
      chk("t3_terr_sticky", timeout_err, 1);
      chk("t3_tid_kept", timeout_id, 1);

      // 6: reset on the 2nd busy cycle clears the lock and rr_ptr
      do_reset();
      req = 2'b01;
      exp_q.push_back(mk(2'b01, P0, 2));
      exp_q.push_back(mk(2'b01, P0, 2));
      wait_start(lat);
      req = 2'b11;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("t6_grant", grant, 0);
      chk("t6_busy", busy, 0);
      chk("t6_start", start, 0);
      reset = 1'b0;
      wait_start(lat);
      chk("t6_latency", lat, 1);
      req = '0;
      pulse_done(2);

      repeat (3) @(negedge clock);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sys_array_lock_arbiter.md
Name: sys_array_lock_arbiter

Overview:
Arbitrates exclusive ownership of one systolic-array resource port (compute or load path) between NUM_REQ hardware threads. Picks one requester round-robin and latches that requester's address payload. It issues a start pulse to the sys array controller and holds the lock until the controller reports finished or a hold timeout fires. One instance is used for the comp path and one for the load path, between the thread units and sys_array_controller.

Parameters:
NUM_REQ, 2, number of requesting threads (2..8)
PAYLOAD_W, 96, per-requester payload width (A/D/C addresses, 3 x 32 bits)
MAX_HOLD, 4096, maximum cycles a lock is held without done before forced release (>=2)

Ports:
clock  input  1  system clock
reset  input  1  reset (see Behaviour)
req  input  NUM_REQ  per-thread lock request, level
payload_in  input  NUM_REQ*PAYLOAD_W  flattened payloads; requester i at [i*PAYLOAD_W +: PAYLOAD_W]
done  input  1  one-cycle finished pulse from the resource
grant  output  NUM_REQ  one-hot lock owner, registered
start  output  1  one-cycle pulse on the first grant cycle
payload_out  output  PAYLOAD_W  payload latched from the winner at grant
busy  output  1  lock held (state BUSY)
timeout_err  output  1  sticky forced-release flag
timeout_id  output  $clog2(NUM_REQ)  owner index at the last timeout

Behaviour:
- Reset: clock is clock; reset is reset, synchronous, active-high. Reset applies at any time, including mid-grant, and forces the following values on the next edge:
  - state IDLE
  - grant 0, start 0, busy 0
  - payload_out 0
  - timeout_err 0, timeout_id 0
  - rr_ptr 0, hold_cnt 0
- States: IDLE, BUSY.
- IDLE, with any req bit set at edge t:
  - Winner is the first set bit scanning from rr_ptr upward, modulo NUM_REQ.
  - At edge t the block registers grant=onehot(winner), busy=1, start=1 for exactly one cycle, and payload_out=payload_in[winner].
  - It also sets rr_ptr=(winner+1) mod NUM_REQ and hold_cnt=0, then moves to BUSY.
  - Grant latency is 1 cycle from req visible to grant visible.
- IDLE with no req: hold all registers; done is ignored.
- BUSY:
  - hold_cnt increments every cycle.
  - req changes are ignored; the lock cannot be revoked by the requester, and payload_out stays stable.
  - done=1: next edge clears grant and busy and returns to IDLE.
  - No done and hold_cnt==MAX_HOLD-1: next edge force-releases to IDLE, sets timeout_err=1 and timeout_id=owner index.
  - done coincident with the timeout condition: treated as a normal release; timeout_err is unchanged.
- Back-to-back: after a release there is a minimum of 1 IDLE cycle before the next grant, because arbitration happens in IDLE.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 lock tenures.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD)+1 and must not wrap.
  - rr_ptr width is $clog2(NUM_REQ).
  - When NUM_REQ is not a power of 2, rr_ptr wraps explicitly at NUM_REQ-1 to 0.
- timeout_err clears only on reset. A second timeout overwrites timeout_id.
- start and grant[i] assert in the same cycle. The controller samples payload_out on start.

Decomposition:
- Shared package sys_array_pkg:
  - arb_state_t enum {IDLE, BUSY}
  - localparam ADDR_W=32 and the PAYLOAD_W = 3*ADDR_W convention
  - function clog2_min1 for index widths
- Sub-module rr_picker (combinational): inputs req and rr_ptr; outputs winner index and any_req. Implemented as a rotate, priority-encode, then un-rotate.
- The arbiter FSM, payload latch and counters stay in the top.

Test Plan:
1. After reset, req=01, payload_in[0]=0x000000AA_000000BB_000000CC; done pulsed 5 cycles after grant -> grant=01 and start=1 one cycle after req, payload_out=that value, busy=1 for 5 cycles, grant=00 the cycle after done.
2. req=11 held from reset, done 3 cycles after each grant -> grants alternate 01, 10, 01, with exactly one IDLE cycle between tenures.
3. MAX_HOLD=8, req=10, done never sent -> grant=10 for 8 cycles, then 00; timeout_err=1, timeout_id=1; after req=01, a new grant=01 issues normally and timeout_err stays 1.
4. MAX_HOLD=8, done asserted exactly on cycle 8 of the tenure -> release with timeout_err=0.
5. Requester 0 drops req mid-tenure while req1 is asserted -> grant stays 01 until done; payload_out unchanged despite payload_in toggling.
6. reset asserted on the 2nd BUSY cycle -> next cycle grant=00, busy=0, rr_ptr=0; with req=11 after reset, requester 0 is granted first.
